search_and_add: RTL and testbench

//  Word-count accumulator for the wordcount pipeline.
//  - Queues {key,value} records and, on kick, drains the queue.
//  - Each key is looked up in an internal associative table; a hit adds value to the stored count, a miss allocates a new entry.
//  - Every table update is mirrored on the accum_* write port so downstream memory holds {key,count} per entry index.

---
 rtl/search_and_add_pkg.sv | 38 +++
 rtl/saa_fifo.sv | 64 ++++++
 rtl/search_and_add.sv | 172 +++++++++++++++++
 tb/tb_search_and_add.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/search_and_add_pkg.sv
// Shared widths, depths, FSM state encoding and record layout for the
// wordcount search_and_add block. The count update helper honours the
// optional SEARCH_AND_ADD_SATURATE_EN build macro (saturating vs wrapping add).
package search_and_add_pkg;

    localparam int KEY_W       = 128;
    localparam int VAL_W       = 32;
    localparam int ENTRY_W     = KEY_W + VAL_W;
    localparam int FIFO_DEPTH  = 16;
    localparam int TABLE_DEPTH = 16;
    localparam int TBL_IDX_W   = $clog2(TABLE_DEPTH);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        FETCH  = 3'd2,
        SEARCH = 3'd3,
        UPDATE = 3'd4
    } state_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } entry_t;

    // New count for a table hit: saturating or modulo-2^VAL_W addition.
    function automatic logic [VAL_W-1:0] add_count(input logic [VAL_W-1:0] a,
                                                   input logic [VAL_W-1:0] b);
`ifdef SEARCH_AND_ADD_SATURATE_EN
        logic [VAL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[VAL_W] ? {VAL_W{1'b1}} : sum[VAL_W-1:0];
`else
        return a + b;
`endif
    endfunction

endpackage

// File: rtl/saa_fifo.sv
// Synchronous input-record queue for search_and_add. Push is ignored when
// full, pop is ignored when empty; simultaneous push and pop are both honoured.
// Read data is registered on pop and held until the next pop.
module saa_fifo #(
    parameter int WIDTH = 160,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             re,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             push;
    logic             pop;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign push  = we && !full;
    assign pop   = re && !empty;
    assign dout  = dout_reg;

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                dout_reg   <= mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/search_and_add.sv
// Word-count accumulator: queues {key,value} records and, on kick, drains
// the queue through an associative table (hit adds, miss allocates lowest
// free slot, full table drops). Every table update is mirrored on accum_*.
// Build option: SEARCH_AND_ADD_SATURATE_EN makes hit addition saturate.
module search_and_add
    import search_and_add_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    output logic               ready,
    input  logic               kick,
    output logic               busy,
    input  logic [ENTRY_W-1:0] din,
    input  logic               we,
    output logic               full,
    output logic [31:0]        accum_addr,
    output logic [ENTRY_W-1:0] accum_din,
    output logic               accum_we
);

    state_t                 state_reg;
    logic [TBL_IDX_W-1:0]   init_idx_reg;
    logic                   hit_reg;
    logic                   free_reg;
    logic [TBL_IDX_W-1:0]   idx_reg;

    logic                   fifo_re;
    logic                   fifo_empty;
    logic [ENTRY_W-1:0]     fifo_dout;
    entry_t                 rec;

    logic [TABLE_DEPTH-1:0] valid_reg;
    logic [KEY_W-1:0]       key_mem [TABLE_DEPTH];
    logic [VAL_W-1:0]       cnt_mem [TABLE_DEPTH];

    logic [TABLE_DEPTH-1:0] hit_vec;
    logic                   hit_any;
    logic [TBL_IDX_W-1:0]   hit_idx;
    logic                   free_any;
    logic [TBL_IDX_W-1:0]   free_idx;
    logic [VAL_W-1:0]       new_count;
    logic                   do_write;

    saa_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .din   (din),
        .full  (full),
        .re    (fifo_re),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    assign rec     = entry_t'(fifo_dout);
    assign fifo_re = (state_reg == FETCH) && !fifo_empty;

    // Parallel key compare against every valid entry.
    generate
        for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_cmp
            assign hit_vec[gi] = valid_reg[gi] && (key_mem[gi] == rec.key);
        end
    endgenerate

    // Priority encoders: lowest matching index and lowest free index.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_any = 1'b1;
                hit_idx = TBL_IDX_W'(i);
            end
            if (!valid_reg[i]) begin
                free_any = 1'b1;
                free_idx = TBL_IDX_W'(i);
            end
        end
    end

    assign new_count = hit_reg ? add_count(cnt_mem[idx_reg], rec.val) : rec.val;
    assign do_write  = (state_reg == UPDATE) && (hit_reg || free_reg);

    // Control FSM: table init, idle/kick handshake and fetch-search-update loop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= INIT;
            init_idx_reg <= '0;
            ready        <= 1'b0;
            busy         <= 1'b0;
            hit_reg      <= 1'b0;
            free_reg     <= 1'b0;
            idx_reg      <= '0;
        end else begin
            case (state_reg)
                INIT: begin
                    init_idx_reg <= init_idx_reg + 1'b1;
                    if (init_idx_reg == TBL_IDX_W'(TABLE_DEPTH - 1)) begin
                        ready     <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                IDLE: begin
                    if (kick) begin
                        busy      <= 1'b1;
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (fifo_empty) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        state_reg <= SEARCH;
                    end
                end
                SEARCH: begin
                    hit_reg   <= hit_any;
                    free_reg  <= free_any;
                    idx_reg   <= hit_any ? hit_idx : free_idx;
                    state_reg <= UPDATE;
                end
                UPDATE: begin
                    state_reg <= FETCH;
                end
                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

    // Valid bits: cleared one per cycle during INIT, set on allocation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= '0;
        end else if (state_reg == INIT) begin
            valid_reg[init_idx_reg] <= 1'b0;
        end else if (do_write && !hit_reg) begin
            valid_reg[idx_reg] <= 1'b1;
        end
    end

    // Key and count storage; a hit rewrites the identical key harmlessly.
    always_ff @(posedge clk) begin
        if (do_write) begin
            key_mem[idx_reg] <= rec.key;
            cnt_mem[idx_reg] <= new_count;
        end
    end

    // Mirror each table update on the accum write port; hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accum_we   <= 1'b0;
            accum_addr <= '0;
            accum_din  <= '0;
        end else begin
            accum_we <= do_write;
            if (do_write) begin
                accum_addr <= 32'(idx_reg);
                accum_din  <= {rec.key, new_count};
            end
        end
    end

endmodule

// File: tb/tb_search_and_add.sv
// Directed bench for search_and_add: init timing, single record, duplicate
// accumulation, queue full, table full / wrap-or-saturate, reset mid-drain.
module tb_search_and_add;
    import search_and_add_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               ready;
    logic               kick = 1'b0;
    logic               busy;
    logic [ENTRY_W-1:0] din = '0;
    logic               we = 1'b0;
    logic               full;
    logic [31:0]        accum_addr;
    logic [ENTRY_W-1:0] accum_din;
    logic               accum_we;

    int checks = 0;
    int errors = 0;
    logic [191:0] got [$];

    localparam logic [127:0] K1 = 128'hDEADBEEF_ABADCAFE_FEFEFEFE_34343434;
    localparam logic [127:0] K2 = 128'h01234567_89ABCDEF_00112233_44556677;

    search_and_add dut (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .kick       (kick),
        .busy       (busy),
        .din        (din),
        .we         (we),
        .full       (full),
        .accum_addr (accum_addr),
        .accum_din  (accum_din),
        .accum_we   (accum_we)
    );

    always #5 clk = ~clk;

    // Capture every accum write as {addr, key, count}.
    always @(negedge clk) begin
        if (accum_we === 1'b1) begin
            got.push_back({accum_addr, accum_din});
            $display("accum write: addr=%0d key=%h count=%h", accum_addr,
                     accum_din[159:32], accum_din[31:0]);
        end
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] kf(input int j);
        return {96'hF00D0000_00000000_00000000, 32'(j)};
    endfunction

    function automatic logic [191:0] wr(input logic [31:0] a, input logic [127:0] k,
                                        input logic [31:0] v);
        return {a, k, v};
    endfunction

    task automatic check_write(input int i, input logic [191:0] exp);
        logic [191:0] obs;
        obs = (i < got.size()) ? got[i] : {192{1'bx}};
        checkw($sformatf("write%0d", i), obs, exp);
    endtask

    // Called at a negedge; pushes one record during the following cycle.
    task automatic push(input logic [127:0] k, input logic [31:0] v);
        din = {k, v};
        we  = 1'b1;
        @(negedge clk);
        we  = 1'b0;
        $display("push key=%h value=%h full=%b", k, v, full);
    endtask

    // Called at a negedge; kicks and waits (bounded) for the drain to end.
    task automatic kick_run(input string tag);
        int n;
        got.delete();
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check1({tag, "_drain_done"}, busy, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        int n;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check1({tag, "_ready"}, ready, 1'b1);
    endtask

    initial begin
        int c1;
        int c2;
        int n;

        // 1. Reset values and INIT duration.
        repeat (3) @(negedge clk);
        check1("rst_ready", ready, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_full", full, 1'b0);
        check1("rst_accum_we", accum_we, 1'b0);
        checkw("rst_accum_addr", 192'(accum_addr), 192'(0));
        checkw("rst_accum_din", 192'(accum_din), 192'(0));
        reset = 1'b1;
        for (int k = 1; k <= TABLE_DEPTH; k++) begin
            @(posedge clk);
            #1;
            check1($sformatf("init_ready_c%0d", k), ready, (k == TABLE_DEPTH));
            check1($sformatf("init_busy_c%0d", k), busy, 1'b0);
            check1($sformatf("init_we_c%0d", k), accum_we, 1'b0);
        end
        @(negedge clk);

        // 2. Single record allocates index 0.
        push(K1, 32'h5A5A5A5A);
        check1("t2_full", full, 1'b0);
        kick_run("t2");
        checkw("t2_count", 192'(got.size()), 192'(1));
        check_write(0, wr(32'd0, K1, 32'h5A5A5A5A));

        // 3. Fresh table: duplicate key accumulates, new key takes index 1.
        do_reset("t3");
        push(K1, 32'd1);
        push(K1, 32'd2);
        push(K2, 32'd7);
        kick_run("t3");
        checkw("t3_count", 192'(got.size()), 192'(3));
        check_write(0, wr(32'd0, K1, 32'd1));
        check_write(1, wr(32'd0, K1, 32'd3));
        check_write(2, wr(32'd1, K2, 32'd7));

        // 4. Fill the queue, extra push dropped, exactly FIFO_DEPTH processed.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            push((i % 2 == 0) ? K1 : K2, 32'(i + 1));
        end
        check1("t4_full", full, 1'b1);
        push(K1, 32'd1000);
        check1("t4_full_after_extra", full, 1'b1);
        kick_run("t4");
        check1("t4_not_full", full, 1'b0);
        checkw("t4_count", 192'(got.size()), 192'(FIFO_DEPTH));
        c1 = 3;
        c2 = 7;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (i % 2 == 0) begin
                c1 += i + 1;
                check_write(i, wr(32'd0, K1, 32'(c1)));
            end else begin
                c2 += i + 1;
                check_write(i, wr(32'd1, K2, 32'(c2)));
            end
        end

        // 5. Fill remaining 14 slots; then a new key is dropped, a hit wraps/saturates.
        for (int j = 0; j < TABLE_DEPTH - 2; j++) begin
            push(kf(j), (j == 0) ? 32'hFFFFFFFF : 32'(j + 100));
        end
        kick_run("t5a");
        checkw("t5a_count", 192'(got.size()), 192'(TABLE_DEPTH - 2));
        for (int j = 0; j < TABLE_DEPTH - 2; j++) begin
            check_write(j, wr(32'(j + 2), kf(j), (j == 0) ? 32'hFFFFFFFF : 32'(j + 100)));
        end
        push(kf(99), 32'd9);
        push(kf(0), 32'd1);
        kick_run("t5b");
        checkw("t5b_count", 192'(got.size()), 192'(1));
`ifdef SEARCH_AND_ADD_SATURATE_EN
        check_write(0, wr(32'd2, kf(0), 32'hFFFFFFFF));
`else
        check_write(0, wr(32'd2, kf(0), 32'h00000000));
`endif

        // 6. Reset in the middle of a drain.
        for (int i = 0; i < 4; i++) begin
            push(kf(1), 32'd1);
        end
        got.delete();
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        n = 0;
        while (!accum_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        check1("t6_mid_write", accum_we, 1'b1);
        check1("t6_mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check1("t6_rst_ready", ready, 1'b0);
        check1("t6_rst_busy", busy, 1'b0);
        check1("t6_rst_full", full, 1'b0);
        check1("t6_rst_we", accum_we, 1'b0);
        checkw("t6_rst_addr", 192'(accum_addr), 192'(0));
        checkw("t6_rst_din", 192'(accum_din), 192'(0));
        @(negedge clk);
        do_reset("t6");
        push(K1, 32'd5);
        kick_run("t6");
        checkw("t6_count", 192'(got.size()), 192'(1));
        check_write(0, wr(32'd0, K1, 32'd5));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
